// File: rtl/counter_4bit_down_if.sv
// Control/status bundle for counter_4bit_down.
// master: the loader/controller; slave: the counter itself.
interface counter_4bit_down_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             done;
  logic [1:0]       state;

  modport master (
    output enable, load, load_value,
    input  count, zero, done, state
  );

  modport slave (
    input  enable, load, load_value,
    output count, zero, done, state
  );
endinterface

// File: rtl/counter_4bit_down.sv
// Loadable saturating down-counter with one-cycle expiry pulse.
// Optional periodic auto-reload from the last loaded value is enabled by
// defining COUNTER_AUTO_RELOAD_EN; without it EXPIRED is sticky.
module counter_4bit_down #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  counter_4bit_down_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             done_q, done_n;

  // State, count, reload value and done pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-count: load beats enable; done only on 1->0.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    done_n   = 1'b0;
    if (bus.load) begin
      reload_n = bus.load_value;
      count_n  = bus.load_value;
      state_n  = (bus.load_value != '0) ? ARMED : EXPIRED;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_n = '0;
        end
        ARMED, RUN: begin
          if (count_q == '0) begin
            state_n = EXPIRED;
          end else if (bus.enable) begin
            count_n = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
              state_n = EXPIRED;
              done_n  = 1'b1;
            end else begin
              state_n = RUN;
            end
          end else begin
            state_n = ARMED;
          end
        end
        EXPIRED: begin
          count_n = '0;
`ifdef COUNTER_AUTO_RELOAD_EN
          if (bus.enable && (reload_q != '0)) begin
            count_n = reload_q;
            state_n = RUN;
          end
`endif
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  // Status outputs.
  always_comb begin
    bus.count = count_q;
    bus.zero  = (count_q == '0);
    bus.done  = done_q;
    bus.state = state_q;
  end

endmodule

// File: tb/tb_counter_4bit_down.sv
// Randomised and directed bench for counter_4bit_down against a behavioural model.
module tb_counter_4bit_down;

  logic clk = 1'b0;
  logic reset = 1'b0;

  counter_4bit_down_if #(.WIDTH(4)) bus ();

  counter_4bit_down #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

`ifdef COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Behavioural model: mode 0 idle, 1 armed, 2 running, 3 expired.
  int m_cnt = 0;
  int m_mode = 0;
  int m_reload = 0;
  int m_done = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_mode = 0; m_reload = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (bus.load) begin
        m_reload = int'(bus.load_value);
        m_cnt    = m_reload;
        m_mode   = (m_cnt == 0) ? 3 : 1;
      end else if (m_mode == 1 || m_mode == 2) begin
        if (bus.enable) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin m_mode = 3; m_done = 1; end
          else m_mode = 2;
        end else begin
          m_mode = 1;
        end
      end else if (m_mode == 3 && AUTO && bus.enable && m_reload != 0) begin
        m_cnt  = m_reload;
        m_mode = 2;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_count", int'(bus.count), m_cnt);
      chk("model_zero",  int'(bus.zero),  (m_cnt == 0) ? 1 : 0);
      chk("model_done",  int'(bus.done),  m_done);
      chk("model_state", int'(bus.state), m_mode);
    end
  end

  // One clock: inputs set after the falling edge, outputs sampled 1ns after rise.
  task automatic cyc(input bit en, input bit ld, input int lv);
    @(negedge clk);
    #1;
    bus.enable     = en;
    bus.load       = ld;
    bus.load_value = 4'(lv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_a[8];
    int dn_a[8];
    bus.enable = 1'b0;
    bus.load = 1'b0;
    bus.load_value = '0;
    #1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_zero",  int'(bus.zero), 1);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1; reset = 1'b1;

    // Enable in IDLE must not move the counter.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      chk("idle_count", int'(bus.count), 0);
      chk("idle_state", int'(bus.state), 0);
      chk("idle_done",  int'(bus.done), 0);
    end

    // Load 5 and count down to expiry.
    cyc(0, 1, 5);
    chk("ld5_count", int'(bus.count), 5);
    chk("ld5_state", int'(bus.state), 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 0);
      if (i < 5) begin
        chk("dn5_count", int'(bus.count), 4 - i);
        chk("dn5_done",  int'(bus.done), (i == 4) ? 1 : 0);
      end
      if (i == 4) begin
        chk("dn5_state", int'(bus.state), 3);
        chk("dn5_zero",  int'(bus.zero), 1);
      end
      if (i > 4 && !AUTO) begin
        chk("exp_hold", int'(bus.count), 0);
        chk("exp_nodone", int'(bus.done), 0);
      end
    end

    // Pause holds the count and returns to ARMED.
    cyc(0, 1, 10);
    repeat (3) cyc(1, 0, 0);
    chk("run_count7", int'(bus.count), 7);
    repeat (4) cyc(0, 0, 0);
    chk("pause_count", int'(bus.count), 7);
    chk("pause_state", int'(bus.state), 1);
    cyc(1, 0, 0);
    chk("resume_count", int'(bus.count), 6);
    chk("resume_state", int'(bus.state), 2);

    // Load colliding with the 1->0 edge wins and suppresses done.
    repeat (5) cyc(1, 0, 0);
    chk("pre_coll_count", int'(bus.count), 1);
    cyc(1, 1, 9);
    chk("coll_count", int'(bus.count), 9);
    chk("coll_state", int'(bus.state), 1);
    chk("coll_done",  int'(bus.done), 0);
    cyc(0, 1, 0);
    chk("ld0_count", int'(bus.count), 0);
    chk("ld0_state", int'(bus.state), 3);
    chk("ld0_done",  int'(bus.done), 0);

    // Asynchronous reset mid-cycle while running.
    cyc(0, 1, 8);
    repeat (2) cyc(1, 0, 0);
    chk("pre_rst_count", int'(bus.count), 6);
    chk("pre_rst_state", int'(bus.state), 2);
    #1; reset = 1'b0; #1;
    chk("async_count", int'(bus.count), 0);
    chk("async_state", int'(bus.state), 0);
    @(negedge clk); #1; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk("post_rst_count", int'(bus.count), 0);
    end

    // Periodic reload (or sticky expiry when the feature is absent).
    cyc(0, 1, 3);
    for (int i = 0; i < 8; i++) begin
      if (AUTO) begin
        exp_a[i] = 3 - ((i + 1) % 4);
        dn_a[i]  = ((i % 4) == 2) ? 1 : 0;
      end else begin
        exp_a[i] = (i < 2) ? 2 - i : 0;
        dn_a[i]  = (i == 2) ? 1 : 0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      chk("ar_count", int'(bus.count), exp_a[i]);
      chk("ar_done",  int'(bus.done), dn_a[i]);
    end

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      bus.enable     = ($urandom_range(3) != 0);
      bus.load       = ($urandom_range(7) == 0);
      bus.load_value = 4'($urandom_range(15));
      if ($urandom_range(59) == 0) begin
        reset = 1'b0; #1; reset = 1'b1;
      end
      @(posedge clk);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
